// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state encoding
// and small decode helpers used by the controller.
package serial_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // 2'd3 is unreachable; the FSM treats it as a fault and steers back to IDLE.
  localparam logic [1:0] ST_LAST_LEGAL = 2'd2;

  function automatic logic state_is_busy(input state_e st);
    return (st == ST_ADD) || (st == ST_DONE);
  endfunction

endpackage

// File: rtl/full_adder_assign.sv
// Single-bit full adder cell built from continuous assignments.
// Purely combinational; no latency, no flow control.
module full_adder_assign (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  logic half_sum;

  assign half_sum = a ^ b;
  assign sum      = half_sum ^ c_in;
  assign c_out    = (a & b) | (c_in & half_sum);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one shared full-adder cell, LSB first, one bit per clock.
// Result valid WIDTH cycles after accept; result held stable until out_ready, one op in flight.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             c_out,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic fa_sum;
  logic fa_cout;
  logic in_fire;
  logic out_fire;
  logic last_bit;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign last_bit = (cnt_q == CNT_LAST);

  full_adder_assign u_fa (
    .a     (a_q[0]),
    .b     (b_q[0]),
    .c_in  (carry_q),
    .sum   (fa_sum),
    .c_out (fa_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_fire)  state_d = ST_ADD;
      ST_ADD:  if (last_bit) state_d = ST_DONE;
      ST_DONE: if (out_fire) state_d = ST_IDLE;
      default:               state_d = ST_IDLE;
    endcase
  end

  // Outputs are pure state decodes so an async reset clears them immediately.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    busy      = state_is_busy(state_q);
    sum_out   = out_valid ? s_q : '0;
    c_out     = out_valid && carry_q;
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_fire) begin
          a_d     = a_in;
          b_d     = b_in;
          s_d     = '0;
          carry_d = c_in;
          cnt_d   = '0;
        end
      end
      ST_ADD: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        s_d     = {fa_sum, s_q[WIDTH-1:1]};
        carry_d = fa_cout;
        cnt_d   = cnt_q + CNT_ONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  a_result_held : assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(sum_out) && $stable(c_out)));

  a_ready_excl_busy : assert property (@(posedge clk) disable iff (!rst_n)
    !(in_ready && busy));

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: WIDTH=8 instance for directed/random ops, WIDTH=2 instance
// for exhaustive back-to-back sweep; expected results from plain integer addition.
module tb_serial_add_ctrl;

  logic       clk;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0] a_in, b_in, sum_out;
  logic       c_in, c_out;

  logic       in_valid2, in_ready2, out_valid2, out_ready2, busy2;
  logic [1:0] a_in2, b_in2, sum_out2;
  logic       c_in2, c_out2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .c_in(c_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum_out(sum_out), .c_out(c_out), .busy(busy)
  );

  serial_add_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .a_in(a_in2), .b_in(b_in2), .c_in(c_in2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .sum_out(sum_out2), .c_out(c_out2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands while IDLE and let the next edge take them.
  task automatic accept(input logic [7:0] a, input logic [7:0] b, input logic c, input string nm);
    in_valid = 1'b1;
    a_in = a; b_in = b; c_in = c;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s ready_before_accept: got %b want 1", nm, in_ready);
    end
    tick();
    in_valid = 1'b0;
    a_in = 8'($urandom); b_in = 8'($urandom); c_in = 1'($urandom);
    total++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL %s busy_after_accept: got busy=%b in_ready=%b want 1/0", nm, busy, in_ready);
    end
  endtask

  // Called one step after the accepting edge; counts edges until out_valid.
  task automatic wait_result(input logic [7:0] a, input logic [7:0] b, input logic c, input string nm);
    logic [8:0] expv;
    int lat;
    expv = 9'(a) + 9'(b) + 9'(c);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    total++;
    if (lat != 8) begin
      bad++;
      $display("FAIL %s latency: got %0d want 8", nm, lat);
    end
    total++;
    if ({c_out, sum_out} !== expv) begin
      bad++;
      $display("FAIL %s result: got c=%b sum=%h want c=%b sum=%h", nm, c_out, sum_out, expv[8], expv[7:0]);
    end
  endtask

  task automatic release_result(input string nm);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s release: got out_valid=%b in_ready=%b busy=%b want 0/1/0", nm, out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    total++;
    if (out_valid !== 1'b0 || sum_out !== 8'h00 || c_out !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_values: got ov=%b sum=%h c=%b busy=%b rdy=%b want 0/00/0/0/1",
               out_valid, sum_out, c_out, busy, in_ready);
    end
    total++;
    if (out_valid2 !== 1'b0 || sum_out2 !== 2'b00 || in_ready2 !== 1'b1) begin
      bad++;
      $display("FAIL reset_values_w2: got ov=%b sum=%h rdy=%b want 0/0/1", out_valid2, sum_out2, in_ready2);
    end
    rst_n = 1'b1;
    tick();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got rdy=%b ov=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    logic [16:0] vec [4];
    vec[0] = {8'h00, 8'h00, 1'b0};
    vec[1] = {8'hFF, 8'h01, 1'b0};
    vec[2] = {8'hA5, 8'h5A, 1'b1};
    vec[3] = {8'h3C, 8'h0F, 1'b0};
    foreach (vec[i]) begin
      accept(vec[i][16:9], vec[i][8:1], vec[i][0], $sformatf("directed%0d", i));
      wait_result(vec[i][16:9], vec[i][8:1], vec[i][0], $sformatf("directed%0d", i));
      release_result($sformatf("directed%0d", i));
    end
  endtask

  task automatic test_backpressure();
    accept(8'h3C, 8'h0F, 1'b0, "bp");
    wait_result(8'h3C, 8'h0F, 1'b0, "bp");
    for (int k = 0; k < 5; k++) begin
      tick();
      total++;
      if (out_valid !== 1'b1 || sum_out !== 8'h4B || c_out !== 1'b0 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold%0d: got ov=%b sum=%h c=%b rdy=%b want 1/4b/0/0", k, out_valid, sum_out, c_out, in_ready);
      end
    end
    out_ready = 1'b1;
    in_valid = 1'b1;
    a_in = 8'h77; b_in = 8'h11; c_in = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL bp_not_taken_in_done: got rdy=%b ov=%b busy=%b want 1/0/0", in_ready, out_valid, busy);
    end
    accept(8'h77, 8'h11, 1'b1, "bp_next");
    wait_result(8'h77, 8'h11, 1'b1, "bp_next");
    release_result("bp_next");
  endtask

  task automatic test_reset_mid_op();
    int seen;
    accept(8'hAB, 8'hCD, 1'b1, "abort");
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || sum_out !== 8'h00 || c_out !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL abort_reset_values: got ov=%b sum=%h c=%b busy=%b rdy=%b want 0/00/0/0/1",
               out_valid, sum_out, c_out, busy, in_ready);
    end
    tick();
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (out_valid === 1'b1) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL abort_no_result: got %0d valid cycles want 0", seen);
    end
    accept(8'h12, 8'h34, 1'b0, "after_abort");
    wait_result(8'h12, 8'h34, 1'b0, "after_abort");
    release_result("after_abort");
  endtask

  task automatic test_random();
    logic [7:0] a, b;
    logic       c;
    logic [8:0] expv;
    int         stall;
    for (int n = 0; n < 16; n++) begin
      a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
      expv = 9'(a) + 9'(b) + 9'(c);
      stall = $urandom_range(0, 3);
      accept(a, b, c, $sformatf("rand%0d", n));
      wait_result(a, b, c, $sformatf("rand%0d", n));
      for (int k = 0; k < stall; k++) begin
        tick();
        total++;
        if (out_valid !== 1'b1 || {c_out, sum_out} !== expv) begin
          bad++;
          $display("FAIL rand%0d_stall: got ov=%b c=%b sum=%h want 1/%b/%h", n, out_valid, c_out, sum_out, expv[8], expv[7:0]);
        end
      end
      release_result($sformatf("rand%0d", n));
    end
  endtask

  task automatic test_back_to_back_w2();
    logic [4:0] v;
    logic [2:0] expv;
    int n, lat, acc, prev;
    prev = 0;
    out_ready2 = 1'b1;
    in_valid2  = 1'b1;
    for (int i = 0; i < 32; i++) begin
      v = 5'(i);
      a_in2 = v[1:0]; b_in2 = v[3:2]; c_in2 = v[4];
      expv = 3'(v[1:0]) + 3'(v[3:2]) + 3'(v[4]);
      n = 0;
      while (in_ready2 !== 1'b1 && n < 10) begin
        tick();
        n++;
      end
      tick();
      acc = cyc;
      if (i > 0) begin
        total++;
        if (acc - prev != 4) begin
          bad++;
          $display("FAIL w2_period%0d: got %0d want 4", i, acc - prev);
        end
      end
      prev = acc;
      lat = 0;
      while (out_valid2 !== 1'b1 && lat < 10) begin
        tick();
        lat++;
      end
      total++;
      if (lat != 2) begin
        bad++;
        $display("FAIL w2_latency%0d: got %0d want 2", i, lat);
      end
      total++;
      if ({c_out2, sum_out2} !== expv) begin
        bad++;
        $display("FAIL w2_result%0d: got %b want %b", i, {c_out2, sum_out2}, expv);
      end
    end
    in_valid2 = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    a_in = '0; b_in = '0; c_in = 1'b0;
    in_valid2 = 1'b0; out_ready2 = 1'b1;
    a_in2 = '0; b_in2 = '0; c_in2 = 1'b0;

    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    test_back_to_back_w2();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
